ifc_driver: RTL and testbench

- Self-checking initiator for the two-put/one-get ifc protocol: drives the a/b put methods, pulls the y get method, and compares y against a locally computed reference.
- Sits opposite the DUT's ifc ports in test wrappers. Replaces free-running bench stimulus with a cycle-accurate, handshake-correct master.
- Reports pass/fail, error count and timeout status.

---
 rtl/ifc_pkg.sv | 35 +++
 rtl/ifc_vec_gen.sv | 60 ++++++
 rtl/ifc_driver.sv | 189 ++++++++++++++++++
 tb/tb_ifc_driver.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifc_pkg.sv
// ifc_driver shared types: FSM states, reference ops, generator constants.
// Imported by ifc_driver and ifc_vec_gen.
package ifc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PUT   = 3'd1,
    ST_GET   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } ifc_state_e;

  localparam logic [1:0] IFC_OP_OR  = 2'd0;
  localparam logic [1:0] IFC_OP_XOR = 2'd1;
  localparam logic [1:0] IFC_OP_AND = 2'd2;

  // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] IFC_LFSR_SEED = 8'hA5;
  localparam logic [7:0] IFC_LFSR_TAPS = 8'hB8;

  function automatic logic ifc_expect(
    input logic [1:0] op,
    input logic       a,
    input logic       b
  );
    case (op)
      IFC_OP_OR:  return a | b;
      IFC_OP_XOR: return a ^ b;
      IFC_OP_AND: return a & b;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ifc_vec_gen.sv
// ifc_driver operand generator: 2-bit counter, or 8-bit LFSR
// when IFC_DRIVER_LFSR_EN is defined.
module ifc_vec_gen
  import ifc_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic load,
  input  logic advance,
  output logic a,
  output logic b
);

`ifdef IFC_DRIVER_LFSR_EN
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // reseed on load, shift in tap parity on advance
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = IFC_LFSR_SEED;
    end else if (advance) begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & IFC_LFSR_TAPS)};
    end
  end

  // generator register
  always_ff @(posedge CLK) begin
    if (!RST_N) lfsr_q <= IFC_LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign a = lfsr_q[7];
  assign b = lfsr_q[0];
`else
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  // restart at zero on load, wrap 3->0 on advance
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = 2'd0;
    end else if (advance) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  // generator register
  always_ff @(posedge CLK) begin
    if (!RST_N) cnt_q <= 2'd0;
    else        cnt_q <= cnt_d;
  end

  assign a = cnt_q[1];
  assign b = cnt_q[0];
`endif

endmodule

// File: rtl/ifc_driver.sv
// ifc_driver: self-checking a/b put, y get initiator.
// IFC_DRIVER_LFSR_EN selects the LFSR operand generator.
module ifc_driver
  import ifc_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned OP          = 1,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  output logic       a_data,
  output logic       a_en,
  input  logic       a_rdy,
  output logic       b_data,
  output logic       b_en,
  input  logic       b_rdy,
  output logic       y_en,
  input  logic       y_data,
  input  logic       y_rdy,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timed_out,
  output logic [7:0] err_count,
  output logic [7:0] vec_count
);

  localparam logic [1:0] OpSel    = OP[1:0];
  localparam logic [7:0] VecLast  = 8'(NUM_VECTORS);
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  ifc_state_e state_q, state_d;
  logic       a_sent_q, a_sent_d;
  logic       b_sent_q, b_sent_d;
  logic [7:0] wait_q, wait_d;
  logic       y_q, y_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       to_q, to_d;
  logic [7:0] err_q, err_d;
  logic [7:0] vec_q, vec_d;
  logic       gen_load, gen_adv;
  logic       gen_a, gen_b;
  logic       abort;

  ifc_vec_gen u_gen (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .load    (gen_load),
    .advance (gen_adv),
    .a       (gen_a),
    .b       (gen_b)
  );

  assign a_data = gen_a;
  assign b_data = gen_b;

  // reset kills enables combinationally, even mid-handshake
  assign a_en = RST_N & (state_q == ST_PUT) & a_rdy & ~a_sent_q;
  assign b_en = RST_N & (state_q == ST_PUT) & b_rdy & ~b_sent_q;
  assign y_en = RST_N & (state_q == ST_GET) & y_rdy;

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timed_out = to_q;
  assign err_count = err_q;
  assign vec_count = vec_q;

  // run sequencing, handshake tracking, checker and wait timer
  always_comb begin
    state_d  = state_q;
    a_sent_d = a_sent_q;
    b_sent_d = b_sent_q;
    wait_d   = wait_q;
    y_d      = y_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    to_d     = to_q;
    err_d    = err_q;
    vec_d    = vec_q;
    gen_load = 1'b0;
    gen_adv  = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ABORT: begin
        if (start) begin
          state_d  = ST_PUT;
          a_sent_d = 1'b0;
          b_sent_d = 1'b0;
          wait_d   = 8'd0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          to_d     = 1'b0;
          err_d    = 8'd0;
          vec_d    = 8'd0;
          gen_load = 1'b1;
        end
      end
      ST_PUT: begin
        a_sent_d = a_sent_q | a_en;
        b_sent_d = b_sent_q | b_en;
        if (a_sent_d && b_sent_d) begin
          state_d = ST_GET;
          wait_d  = 8'd0;
        end else if (a_en || b_en) begin
          wait_d = 8'd0;
        end else if (wait_q == WaitLast) begin
          abort = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_GET: begin
        if (y_en) begin
          y_d     = y_data;
          state_d = ST_CHECK;
          wait_d  = 8'd0;
        end else if (wait_q == WaitLast) begin
          abort = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_CHECK: begin
        gen_adv = 1'b1;
        vec_d   = vec_q + 8'd1;
        if (ifc_expect(OpSel, gen_a, gen_b) != y_q
            && err_q != 8'hFF) begin
          err_d = err_q + 8'd1;
        end
        if (vec_d == VecLast) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 8'd0);
        end else begin
          state_d  = ST_PUT;
          a_sent_d = 1'b0;
          b_sent_d = 1'b0;
          wait_d   = 8'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_ABORT;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      to_d    = 1'b1;
      pass_d  = 1'b0;
    end
  end

  // state and status registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      a_sent_q <= 1'b0;
      b_sent_q <= 1'b0;
      wait_q   <= 8'd0;
      y_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      to_q     <= 1'b0;
      err_q    <= 8'd0;
      vec_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      a_sent_q <= a_sent_d;
      b_sent_q <= b_sent_d;
      wait_q   <= wait_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      to_q     <= to_d;
      err_q    <= err_d;
      vec_q    <= vec_d;
    end
  end

endmodule

// File: tb/tb_ifc_driver.sv
// Bench for ifc_driver: bench plays the ifc target, a
// transaction-level model predicts every enable and status output.
module tb_ifc_driver;

  localparam int NV  = 4;
  localparam int OPB = 1;
  localparam int TO  = 8;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       start = 1'b0;
  logic       a_rdy = 1'b0;
  logic       b_rdy = 1'b0;
  logic       y_rdy = 1'b0;
  logic       y_data = 1'b0;
  logic       a_data, a_en, b_data, b_en, y_en;
  logic       busy, done, pass, timed_out;
  logic [7:0] err_count, vec_count;

  always #5 CLK = ~CLK;

  ifc_driver #(
    .NUM_VECTORS (NV),
    .OP          (OPB),
    .TIMEOUT     (TO)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .a_data    (a_data),
    .a_en      (a_en),
    .a_rdy     (a_rdy),
    .b_data    (b_data),
    .b_en      (b_en),
    .b_rdy     (b_rdy),
    .y_en      (y_en),
    .y_data    (y_data),
    .y_rdy     (y_rdy),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timed_out (timed_out),
    .err_count (err_count),
    .vec_count (vec_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic fref(logic a, logic b);
    case (OPB)
      0:       return a | b;
      1:       return a ^ b;
      default: return a & b;
    endcase
  endfunction

  // operands {a,b} of the k-th vector of a run
  function automatic logic [1:0] vec_ab(int k);
`ifdef IFC_DRIVER_LFSR_EN
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < k; i++)
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return {l[7], l[0]};
`else
    return 2'(k % 4);
`endif
  endfunction

  // transaction-level model
  bit   m_busy, m_done, m_pass, m_to;
  bit   m_ga, m_gb, m_chk;
  logic m_y;
  int   m_err, m_vec, m_k, m_idle;

  initial begin
    logic       ea, eb, ey, ph_put, ph_get;
    logic [1:0] v;
    forever begin
      @(negedge CLK);
      ph_put = m_busy && !m_chk && !(m_ga && m_gb);
      ph_get = m_busy && !m_chk && m_ga && m_gb;
      ea = RST_N && ph_put && !m_ga && a_rdy;
      eb = RST_N && ph_put && !m_gb && b_rdy;
      ey = RST_N && ph_get && y_rdy;
      v  = vec_ab(m_k);
      check("a_en", a_en, ea);
      check("b_en", b_en, eb);
      check("y_en", y_en, ey);
      if (ea) check("a_data", a_data, v[1]);
      if (eb) check("b_data", b_data, v[0]);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("pass", pass, m_pass);
      check("timed_out", timed_out, m_to);
      check("err_count", err_count, m_err);
      check("vec_count", vec_count, m_vec);
      if (!RST_N) begin
        m_busy = 0; m_done = 0; m_pass = 0; m_to = 0;
        m_err = 0; m_vec = 0; m_k = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_done = 0; m_pass = 0; m_to = 0;
          m_err = 0; m_vec = 0; m_k = 0;
          m_ga = 0; m_gb = 0; m_chk = 0; m_idle = 0;
        end
      end else if (m_chk) begin
        if (m_y !== fref(v[1], v[0]) && m_err < 255) m_err++;
        m_vec++;
        m_k++;
        if (m_vec == NV) begin
          m_busy = 0; m_done = 1; m_pass = (m_err == 0);
        end else begin
          m_ga = 0; m_gb = 0; m_chk = 0; m_idle = 0;
        end
      end else begin
        if (ea) m_ga = 1;
        if (eb) m_gb = 1;
        if (ey) begin
          m_chk = 1; m_y = y_data; m_idle = 0;
        end else if (ea || eb) begin
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == TO) begin
            m_busy = 0; m_done = 1; m_to = 1; m_pass = 0;
          end
        end
      end
    end
  end

  // target emulation and observation
  int   cnt = 0;
  int   pa = 100, pb = 100, py = 100, pbad = 0;
  bit   y_mode = 0, y_block = 0;
  int   a_hold = 0;
  bit   r_ha = 0, r_hb = 0, r_bad = 0;
  logic r_a = 0, r_b = 0;
  int   qa[$], qb[$], qta[$], qtb[$];
  int   n_fy = 0;
  int   sa[$], sb[$];

  task automatic cyc();
    logic fa, fb, fy, da, db, rs;
    @(negedge CLK);
    cnt++;
    fa = a_en; fb = b_en; fy = y_en;
    da = a_data; db = b_data; rs = RST_N;
    if (rs && fa) begin qa.push_back(da); qta.push_back(cnt); end
    if (rs && fb) begin qb.push_back(db); qtb.push_back(cnt); end
    if (rs && fy) n_fy++;
    @(posedge CLK);
    #1;
    if (!rs) begin
      r_ha = 0; r_hb = 0;
    end else begin
      if (fa) begin r_ha = 1; r_a = da; end
      if (fb) begin r_hb = 1; r_b = db; end
      if (fy) begin
        r_ha = 0; r_hb = 0;
        r_bad = ($urandom_range(0, 99) < pbad);
      end
    end
    if (a_hold > 0) begin
      a_rdy = 0; a_hold--;
    end else begin
      a_rdy = ($urandom_range(0, 99) < pa);
    end
    b_rdy = ($urandom_range(0, 99) < pb);
    if (r_ha && r_hb && !y_block) begin
      y_rdy  = ($urandom_range(0, 99) < py);
      y_data = y_mode ? (r_a | r_b) : (fref(r_a, r_b) ^ r_bad);
    end else begin
      y_rdy = 0; y_data = 0;
    end
  endtask

  task automatic clr();
    qa.delete(); qb.delete(); qta.delete(); qtb.delete();
    n_fy = 0;
  endtask

  task automatic kick(output int c0);
    start = 1;
    cyc();
    start = 0;
    c0 = cnt;
  endtask

  task automatic run(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!done && n < 200);
  endtask

  task automatic check_seq(string tag);
    int ea[4];
    int eb[4];
    ea = '{0, 0, 1, 1};
    eb = '{0, 1, 0, 1};
    check({tag, "_na"}, qa.size(), 4);
    check({tag, "_nb"}, qb.size(), 4);
    if (qa.size() >= 4 && qb.size() >= 4) begin
`ifdef IFC_DRIVER_LFSR_EN
      check({tag, "_a0"}, qa[0], 1);
      check({tag, "_b0"}, qb[0], 1);
`else
      for (int i = 0; i < 4; i++) begin
        check({tag, "_a"}, qa[i], ea[i]);
        check({tag, "_b"}, qb[i], eb[i]);
      end
`endif
    end
  endtask

  initial begin
    int n, c0;
    RST_N = 0;
    cyc();
    cyc();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_to", timed_out, 0);
    check("rst_err", err_count, 0);
    check("rst_vec", vec_count, 0);
    check("rst_a_en", a_en, 0);
    check("rst_y_en", y_en, 0);
    RST_N = 1;
    cyc();

    // golden XOR target
    clr();
    kick(c0);
    run(n);
    check("gold_lat", n, 12);
    check("gold_pass", pass, 1);
    check("gold_err", err_count, 0);
    check("gold_vec", vec_count, 4);
    check_seq("gold");
    sa = qa; sb = qb;

    // target computes OR: (1,1) mismatches
    clr();
    y_mode = 1;
    kick(c0);
    run(n);
    y_mode = 0;
    check("or_done", done, 1);
    check("or_err", err_count, 1);
    check("or_pass", pass, 0);

    // a_rdy low for five PUT cycles
    clr();
    a_rdy = 0;
    a_hold = 5;
    kick(c0);
    run(n);
    check("stall_b_t", qtb.size() > 0 ? qtb[0] : -1, c0 + 1);
    check("stall_a_t", qta.size() > 0 ? qta[0] : -1, c0 + 6);
    check("stall_na", qa.size(), 4);
    check("stall_nb", qb.size(), 4);
    check("stall_pass", pass, 1);

    // y never ready
    clr();
    y_block = 1;
    kick(c0);
    run(n);
    y_block = 0;
    check("to_lat", n, 9);
    check("to_flag", timed_out, 1);
    check("to_pass", pass, 0);
    check("to_busy", busy, 0);
    check("to_ny", n_fy, 0);

    // reset while in GET
    clr();
    kick(c0);
    cyc();
    check("rg_yrdy", y_rdy, 1);
    RST_N = 0;
    #1;
    check("rg_y_en", y_en, 0);
    cyc();
    RST_N = 1;
    check("rg_busy", busy, 0);
    check("rg_done", done, 0);
    check("rg_err", err_count, 0);
    check("rg_vec", vec_count, 0);
    clr();
    kick(c0);
    run(n);
    check("rg_pass", pass, 1);
    check_seq("replay");
    check("replay_n", qa.size(), sa.size());
    for (int i = 0; i < qa.size() && i < sa.size(); i++) begin
      check("replay_a", qa[i], sa[i]);
      check("replay_b", qb[i], sb[i]);
    end

    // randomized traffic, stray starts and resets
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        pa   = $urandom_range(40, 100);
        pb   = $urandom_range(40, 100);
        py   = $urandom_range(40, 100);
        pbad = $urandom_range(0, 30);
      end
      start = ($urandom_range(0, 99) < 6);
      RST_N = ($urandom_range(0, 399) != 0);
      cyc();
    end
    start = 0;
    RST_N = 1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
